// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// opcode classes and datapath select values.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_ADR = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  typedef enum logic [3:0] {
    CLS_LOAD, CLS_STORE, CLS_R, CLS_I, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILLEGAL
  } op_class_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_PASSB  = 2'b11;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_fsm_op_decode.sv
// Opcode classifier: maps the 7-bit opcode to an instruction class, with the
// jalr/lui/auipc group only recognised when EN_UJ is set.
module ctrl_op_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int EN_UJ = 1
) (
  input  logic [6:0] op,
  output op_class_t  op_class,
  output logic       legal
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (op)
      OP_LOAD:   op_class = CLS_LOAD;
      OP_STORE:  op_class = CLS_STORE;
      OP_R:      op_class = CLS_R;
      OP_I:      op_class = CLS_I;
      OP_BRANCH: op_class = CLS_BRANCH;
      OP_JAL:    op_class = CLS_JAL;
      OP_JALR:   if (EN_UJ != 0) op_class = CLS_JALR;
      OP_LUI:    if (EN_UJ != 0) op_class = CLS_LUI;
      OP_AUIPC:  if (EN_UJ != 0) op_class = CLS_AUIPC;
      default:   op_class = CLS_ILLEGAL;
    endcase
    legal = (op_class != CLS_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences each instruction and
// drives datapath selects, write enables and the retired-instruction counter.
module multicycle_ctrl_fsm
  import multicycle_ctrl_pkg::*;
#(
  parameter int EN_UJ     = 1,
  parameter int MEM_HS    = 1,
  parameter int TRAP_HALT = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             branch,
  output logic             pc_update,
  output logic             reg_write,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_srcA,
  output logic [1:0]       alu_srcB,
  output logic             adr_src,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  state_t           state_reg;
  logic [CNT_W-1:0] instret_reg;
  op_class_t        op_class;
  logic             op_legal;
  logic             mem_rdy;

  logic mem_req_c, branch_c, pc_update_c, reg_write_c, mem_write_c, ir_write_c;

  assign mem_rdy = (MEM_HS != 0) ? mem_ready : 1'b1;

  ctrl_op_decode #(.EN_UJ(EN_UJ)) u_op_decode (
    .op      (op),
    .op_class(op_class),
    .legal   (op_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
    end else begin
      case (state_reg)
        S_FETCH:  if (mem_rdy) state_reg <= S_DECODE;
        S_DECODE: begin
          if (!op_legal) begin
            state_reg <= S_TRAP;
          end else begin
            case (op_class)
              CLS_LOAD, CLS_STORE: state_reg <= S_MEMADR;
              CLS_R:      state_reg <= S_EXEC_R;
              CLS_I:      state_reg <= S_EXEC_I;
              CLS_BRANCH: state_reg <= S_BRANCH;
              CLS_JAL:    state_reg <= S_JAL;
              CLS_JALR:   state_reg <= S_JALR_ADR;
              CLS_LUI:    state_reg <= S_LUI;
              CLS_AUIPC:  state_reg <= S_AUIPC;
              default:    state_reg <= S_TRAP;
            endcase
          end
        end
        S_MEMADR: begin
          if (op_class == CLS_LOAD)       state_reg <= S_MEMREAD;
          else if (op_class == CLS_STORE) state_reg <= S_MEMWRITE;
          else                            state_reg <= S_TRAP;
        end
        S_MEMREAD: if (mem_rdy) state_reg <= S_MEMWB;
        // Retirement points: the last state of every completed instruction.
        S_MEMWB, S_BRANCH, S_ALUWB: begin
          state_reg   <= S_FETCH;
          instret_reg <= instret_reg + CNT_W'(1);
        end
        S_MEMWRITE: begin
          if (mem_rdy) begin
            state_reg   <= S_FETCH;
            instret_reg <= instret_reg + CNT_W'(1);
          end
        end
        S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_JAL: state_reg <= S_ALUWB;
        S_JALR_ADR: state_reg <= S_JAL;
        S_TRAP:     if (TRAP_HALT == 0) state_reg <= S_FETCH;
        default:    state_reg <= S_TRAP;
      endcase
    end
  end

  // Decoded from state rather than registered: FETCH and MEMWRITE enables
  // must follow mem_ready within the same cycle.
  always_comb begin
    mem_req_c   = 1'b0;
    branch_c    = 1'b0;
    pc_update_c = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    illegal     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_srcA    = SRCA_PC;
    alu_srcB    = SRCB_RS2;
    adr_src     = ADR_PC;
    alu_op      = ALU_ADD;
    case (state_reg)
      S_FETCH: begin
        mem_req_c   = 1'b1;
        alu_srcB    = SRCB_FOUR;
        result_src  = RES_ALURESULT;
        ir_write_c  = mem_rdy;
        pc_update_c = mem_rdy;
      end
      S_DECODE:   begin alu_srcA = SRCA_OLDPC; alu_srcB = SRCB_IMM; end
      S_MEMADR:   begin alu_srcA = SRCA_RS1;   alu_srcB = SRCB_IMM; end
      S_MEMREAD:  begin mem_req_c = 1'b1; adr_src = ADR_RESULT; end
      S_MEMWB:    begin result_src = RES_READDATA; reg_write_c = 1'b1; end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        adr_src     = ADR_RESULT;
        mem_write_c = mem_rdy;
      end
      S_EXEC_R:   begin alu_srcA = SRCA_RS1; alu_op = ALU_FUNCT; end
      S_EXEC_I:   begin alu_srcA = SRCA_RS1; alu_srcB = SRCB_IMM; alu_op = ALU_FUNCT; end
      S_ALUWB:    reg_write_c = 1'b1;
      S_BRANCH:   begin alu_srcA = SRCA_RS1; alu_op = ALU_BRANCH; branch_c = 1'b1; end
      S_JAL:      begin alu_srcA = SRCA_OLDPC; alu_srcB = SRCB_FOUR; pc_update_c = 1'b1; end
      S_JALR_ADR: begin alu_srcA = SRCA_RS1; alu_srcB = SRCB_IMM; end
      S_LUI:      begin alu_srcB = SRCB_IMM; alu_op = ALU_PASSB; end
      S_AUIPC:    begin alu_srcA = SRCA_OLDPC; alu_srcB = SRCB_IMM; end
      S_TRAP:     illegal = 1'b1;
      default:    illegal = 1'b0;
    endcase
  end

  // Enables are forced low for the whole reset interval, not just after an edge.
  assign mem_req   = mem_req_c   & rst_n;
  assign branch    = branch_c    & rst_n;
  assign pc_update = pc_update_c & rst_n;
  assign reg_write = reg_write_c & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign ir_write  = ir_write_c  & rst_n;

  assign instret = instret_reg;
  assign state_o = state_reg;

endmodule
